fifo_burst_source: RTL and testbench

Push-side transmitter for the team's valid/grant FIFO: on a start pulse it emits a burst of `burst_len_i` words into a FIFO push port, honouring backpressure and inserting a programmable idle gap between words. The data path is DATA_WIDTH+1 bits wide to match the FIFO, with the MSB carrying an end-of-burst flag. It is used as a traffic generator in front of the FIFO in block and system benches, and as a synthesizable source in loopback tests.

---
 rtl/fifo_burst_source.sv | 123 ++++++++++++
 tb/tb_fifo_burst_source.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_source.sv
// Burst traffic source for the valid/grant FIFO push port; MSB of push_data_o flags the last word.
// Define FIFO_SRC_LFSR_EN to advance the payload with a Galois LFSR instead of an incrementer.
module fifo_burst_source #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16,
`ifdef FIFO_SRC_LFSR_EN
  parameter logic [31:0] LFSR_TAPS  = 32'h80200003,
`endif
  localparam int unsigned LW = $clog2(MAX_BURST) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [LW-1:0]         burst_len_i,
  input  logic [7:0]            gap_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  push_valid_o,
  input  logic                  push_grant_i,
  output logic [DATA_WIDTH:0]   push_data_o,
  output logic [15:0]           sent_count_o
);

  typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

  state_e                state_q, state_d;
  logic [LW-1:0]         remaining_q, remaining_d;
  logic [7:0]            gap_reg_q, gap_reg_d;
  logic [7:0]            gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0] payload_q, payload_d;
  logic [15:0]           sent_count_q, sent_count_d;

  logic                  len_ok;
  logic                  last_word;
  logic [DATA_WIDTH-1:0] seed_eff;
  logic [DATA_WIDTH-1:0] payload_next;

  assign len_ok    = (burst_len_i != '0) && (32'(burst_len_i) <= MAX_BURST);
  assign last_word = (remaining_q == LW'(1));

`ifdef FIFO_SRC_LFSR_EN
  localparam logic [DATA_WIDTH-1:0] Taps = DATA_WIDTH'(LFSR_TAPS);

  // A zero seed would lock the LFSR, so it is promoted to 1.
  assign seed_eff     = (seed_i == '0) ? DATA_WIDTH'(1) : seed_i;
  assign payload_next = payload_q[0] ? ((payload_q >> 1) ^ Taps) : (payload_q >> 1);
`else
  assign seed_eff     = seed_i;
  assign payload_next = payload_q + DATA_WIDTH'(1);
`endif

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    gap_reg_d    = gap_reg_q;
    gap_cnt_d    = gap_cnt_q;
    payload_d    = payload_q;
    sent_count_d = sent_count_q;

    unique case (state_q)
      StIdle: begin
        if (start_i && len_ok) begin
          remaining_d = burst_len_i;
          gap_reg_d   = gap_i;
          payload_d   = seed_eff;
          state_d     = StSend;
        end
      end
      StSend: begin
        if (push_grant_i) begin
          remaining_d  = remaining_q - LW'(1);
          payload_d    = payload_next;
          sent_count_d = sent_count_q + 16'd1;
          if (last_word) begin
            state_d = StDone;
          end else if (gap_reg_q != 8'd0) begin
            state_d   = StGap;
            gap_cnt_d = gap_reg_q;
          end
        end
      end
      StGap: begin
        gap_cnt_d = gap_cnt_q - 8'd1;
        if (gap_cnt_q == 8'd1) begin
          state_d = StSend;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      remaining_q  <= '0;
      gap_reg_q    <= '0;
      gap_cnt_q    <= '0;
      payload_q    <= '0;
      sent_count_q <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      gap_reg_q    <= gap_reg_d;
      gap_cnt_q    <= gap_cnt_d;
      payload_q    <= payload_d;
      sent_count_q <= sent_count_d;
    end
  end

  // Outputs decode from state only, so valid never sees the grant combinationally.
  assign push_valid_o = (state_q == StSend);
  assign push_data_o  = push_valid_o ? {last_word, payload_q} : '0;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);
  assign sent_count_o = sent_count_q;

endmodule

// File: tb/tb_fifo_burst_source.sv
// Self-checking bench for fifo_burst_source: burst-level scoreboard checked every cycle,
// plus directed literal expectations for each scenario.
module tb_fifo_burst_source;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [4:0]  burst_len_i = '0;
  logic [7:0]  gap_i = '0;
  logic [31:0] seed_i = '0;
  logic        push_grant_i = 1'b0;
  logic        busy_o, done_o, push_valid_o;
  logic [32:0] push_data_o;
  logic [15:0] sent_count_o;

  always #5 clk = ~clk;

  fifo_burst_source dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .burst_len_i  (burst_len_i),
    .gap_i        (gap_i),
    .seed_i       (seed_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .push_valid_o (push_valid_o),
    .push_grant_i (push_grant_i),
    .push_data_o  (push_data_o),
    .sent_count_o (sent_count_o)
  );

  typedef struct {
    logic [32:0] data;
    int          gap;
  } exp_t;

  exp_t        q[$];
  logic [32:0] got[$];
  bit          vlog[$];
  bit          log_en = 1'b0;

  int          n_tests = 0;
  int          n_fail = 0;
  int          req_seq = 0;
  int          seen_seq = 0;
  logic [31:0] req_seed;
  int          req_len, req_gap;
  int          model_sent = 0;
  bit          done_next = 1'b0;
  bit          done_exp = 1'b0;
  bit          waiting_gap = 1'b0;
  int          idle_cnt = 0;
  int          exp_gap = 0;
  int          stall_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] adv(input logic [31:0] p);
`ifdef FIFO_SRC_LFSR_EN
    return p[0] ? ((p >> 1) ^ 32'h80200003) : (p >> 1);
`else
    return p + 32'd1;
`endif
  endfunction

  // Expand an accepted burst request into the expected word list.
  task automatic expand();
    logic [31:0] p;
    exp_t        e;
    p = req_seed;
`ifdef FIFO_SRC_LFSR_EN
    if (p == 32'd0) p = 32'd1;
`endif
    for (int i = 0; i < req_len; i++) begin
      e.data = {(i == req_len - 1), p};
      e.gap  = req_gap;
      q.push_back(e);
      p = adv(p);
    end
    waiting_gap = 1'b1;
    idle_cnt    = 0;
    exp_gap     = 0;
  endtask

  task automatic cmp_cycle();
    if (!rst_n) begin
      q.delete();
      model_sent  = 0;
      done_next   = 1'b0;
      done_exp    = 1'b0;
      waiting_gap = 1'b0;
      seen_seq    = req_seq;
      return;
    end
    if (req_seq != seen_seq) begin
      expand();
      seen_seq = req_seq;
    end
    done_exp  = done_next;
    done_next = 1'b0;
    chk("done", done_o, done_exp);
    chk("busy", busy_o, (q.size() != 0) || done_exp);
    chk("count", sent_count_o, model_sent[15:0]);
    if (log_en) vlog.push_back(push_valid_o);
    if (push_valid_o) begin
      if (q.size() == 0) begin
        chk("valid_without_burst", push_valid_o, 0);
      end else begin
        chk("data", push_data_o, q[0].data);
        if (waiting_gap) begin
          chk("gap_len", idle_cnt, exp_gap);
          waiting_gap = 1'b0;
        end
        if (push_grant_i) begin
          got.push_back(push_data_o);
          model_sent++;
          if (q[0].data[32]) begin
            done_next = 1'b1;
          end else begin
            waiting_gap = 1'b1;
            idle_cnt    = 0;
            exp_gap     = q[0].gap;
          end
          void'(q.pop_front());
        end else begin
          stall_cnt++;
        end
      end
    end else if (waiting_gap) begin
      idle_cnt++;
      if (idle_cnt > exp_gap) begin
        chk("gap_len", idle_cnt, exp_gap);
        waiting_gap = 1'b0;
      end
    end
  endtask

  task automatic start_burst(input logic [31:0] s, input int len, input int g);
    bit acc;
    @(posedge clk);
    #1;
    seed_i      = s;
    burst_len_i = 5'(len);
    gap_i       = 8'(g);
    start_i     = 1'b1;
    acc = (len >= 1) && (len <= 16) && (q.size() == 0) && !done_next && !done_exp;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    if (acc) begin
      req_seed = s;
      req_len  = len;
      req_gap  = g;
      req_seq++;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0 && !done_next && !done_exp && !busy_o) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", {(q.size() != 0), done_exp, busy_o}, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_valid"}, push_valid_o, 0);
    chk({tag, "_data"}, push_data_o, 0);
    chk({tag, "_count"}, sent_count_o, 0);
  endtask

  initial begin
    bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    fork
      forever begin
        @(negedge clk);
        cmp_cycle();
      end
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Increment, back-to-back
    push_grant_i = 1'b1;
    got.delete();
    vlog.delete();
    start_burst(32'h10, 4, 0);
    log_en = 1'b1;
    wait_idle();
    log_en = 1'b0;
    chk("b2b_words", got.size(), 4);
    chk("b2b_valid_run", {vlog[0], vlog[1], vlog[2], vlog[3], vlog[4]}, 5'b11110);
`ifndef FIFO_SRC_LFSR_EN
    chk("b2b_w0", got[0], 33'h0_0000_0010);
    chk("b2b_w1", got[1], 33'h0_0000_0011);
    chk("b2b_w2", got[2], 33'h0_0000_0012);
    chk("b2b_w3", got[3], 33'h1_0000_0013);
`endif
    chk("b2b_count", sent_count_o, 4);

    // Gap of 2 between words
    got.delete();
    vlog.delete();
    start_burst(32'h0, 3, 2);
    log_en = 1'b1;
    wait_idle();
    log_en = 1'b0;
    for (int i = 0; i < 7; i++) chk($sformatf("gap_pattern_%0d", i), vlog[i], pat[i]);
`ifndef FIFO_SRC_LFSR_EN
    chk("gap_w2", got[2], 33'h1_0000_0002);
`endif
    chk("gap_count", sent_count_o, 7);

    // Backpressure: grant low for 5 valid cycles
    push_grant_i = 1'b0;
    stall_cnt    = 0;
    got.delete();
    start_burst(32'h20, 2, 0);
    repeat (5) @(posedge clk);
    #1;
    push_grant_i = 1'b1;
    wait_idle();
    chk("bp_stalls", stall_cnt, 5);
    chk("bp_words", got.size(), 2);
`ifndef FIFO_SRC_LFSR_EN
    chk("bp_w0", got[0], 33'h0_0000_0020);
    chk("bp_w1", got[1], 33'h1_0000_0021);
`endif
    chk("bp_count", sent_count_o, 9);

    // Payload wrap, then illegal lengths
    got.delete();
    start_burst(32'hFFFF_FFFF, 2, 0);
    wait_idle();
`ifndef FIFO_SRC_LFSR_EN
    chk("wrap_w0", got[0], 33'h0_FFFF_FFFF);
    chk("wrap_w1", got[1], 33'h1_0000_0000);
`endif
    start_burst(32'h5, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("len0_busy", busy_o, 0);
    chk("len0_valid", push_valid_o, 0);
    start_burst(32'h5, 17, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("len17_busy", busy_o, 0);
    chk("len17_valid", push_valid_o, 0);
    chk("illegal_count", sent_count_o, 11);

    // Start while busy is dropped
    got.delete();
    start_burst(32'h80, 4, 3);
    repeat (2) @(posedge clk);
    start_burst(32'h99, 2, 0);
    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    chk("busy_start_words", got.size(), 4);
`ifndef FIFO_SRC_LFSR_EN
    chk("busy_start_last", got[3], 33'h1_0000_0083);
`endif
    chk("busy_start_count", sent_count_o, 15);

    // Reset after first of 4 words
    got.delete();
    start_burst(32'h40, 4, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_words", got.size(), 1);
`ifndef FIFO_SRC_LFSR_EN
    chk("midrst_w0", got[0], 33'h0_0000_0040);
`endif
    chk("midrst_idle", busy_o, 0);

`ifdef FIFO_SRC_LFSR_EN
    // LFSR sequence from a zero seed
    got.delete();
    start_burst(32'h0, 3, 0);
    wait_idle();
    chk("lfsr_w0", got[0], 33'h0_0000_0001);
    chk("lfsr_w1", got[1], 33'h0_8020_0003);
    chk("lfsr_w2", got[2], 33'h1_C030_0002);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
